// File: rtl/serial_fifo_ctrl.sv
// Buffered COM port: 16-entry RX/TX byte FIFOs behind a DATA/STATUS register pair,
// a level interrupt, and a TX launch FSM for the transmitter's start/busy handshake.
module serial_fifo_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        readEnable_i,
    input  logic        mode_i,
    input  logic [31:0] dataSave_i,
    output logic [31:0] dataLoad_o,
    output logic        int_o,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CntFull = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CntOne  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {StIdle, StLaunch, StArmed, StDrain} tx_state_e;

    logic [7:0]            rx_mem [Depth];
    logic [7:0]            tx_mem [Depth];
    logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic                  overrun_q, overrun_d, rx_int_en_q, rx_int_en_d;
    logic                  enable_q, int_q;
    logic [31:0]           load_q, rd_value, status;
    tx_state_e             state_q;
    logic                  arm_cnt_q, txd_start_q;
    logic [7:0]            txd_data_q;

    logic access, rd_acc, wr_acc, status_wr;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_pop, rx_push, rx_flush, overrun_set;
    logic tx_pop, tx_push, tx_flush;
    logic unused_data;

    assign unused_data = ^dataSave_i[31:8];

    always_comb begin
        access    = enable_i & ~enable_q;
        rd_acc    = access & readEnable_i;
        wr_acc    = access & ~readEnable_i;
        status_wr = wr_acc & mode_i;
        rx_empty  = (rx_cnt_q == '0);
        rx_full   = (rx_cnt_q == CntFull);
        tx_empty  = (tx_cnt_q == '0);
        tx_full   = (tx_cnt_q == CntFull);

        rx_flush    = status_wr & dataSave_i[1];
        tx_flush    = status_wr & dataSave_i[2];
        rx_pop      = rd_acc & ~mode_i & ~rx_empty;
        // A pop in the same cycle frees the slot a full-FIFO push needs
        rx_push     = rxdReady_i & (~rx_full | rx_pop) & ~rx_flush;
        overrun_set = rxdReady_i & rx_full & ~rx_pop & ~rx_flush;
        tx_pop      = (state_q == StIdle) & ~tx_empty & ~txdBusy_i;
        tx_push     = wr_acc & ~mode_i & (~tx_full | tx_pop);

        status                   = '0;
        status[0]                = ~tx_full;
        status[1]                = ~rx_empty;
        status[2]                = overrun_q;
        status[3]                = tx_empty & (state_q == StIdle);
        status[4]                = rx_int_en_q;
        status[8 +: DEPTH_LOG2+1] = rx_cnt_q;

        if (mode_i) begin
            rd_value = status;
        end else if (rx_empty) begin
            rd_value = '0;
        end else begin
            rd_value = {24'b0, rx_mem[rx_rptr_q]};
        end

        if (!enable_i) begin
            dataLoad_o = '0;
        end else if (access) begin
            dataLoad_o = rd_value;
        end else begin
            dataLoad_o = load_q;
        end
    end

    always_comb begin
        rx_wptr_d   = rx_push ? rx_wptr_q + PtrOne : rx_wptr_q;
        rx_rptr_d   = rx_pop ? rx_rptr_q + PtrOne : rx_rptr_q;
        rx_cnt_d    = rx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CntOne;
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CntOne;

        tx_wptr_d   = tx_push ? tx_wptr_q + PtrOne : tx_wptr_q;
        tx_rptr_d   = tx_pop ? tx_rptr_q + PtrOne : tx_rptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CntOne;
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CntOne;

        overrun_d = overrun_q;
        if (rd_acc && mode_i) overrun_d = 1'b0;
        if (overrun_set) overrun_d = 1'b1;
        rx_int_en_d = status_wr ? dataSave_i[0] : rx_int_en_q;

        if (rx_flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
            overrun_d = 1'b0;
        end
        // The FSM may still capture the head byte this cycle; it goes out regardless
        if (tx_flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= rxdData_i;
        if (tx_push) tx_mem[tx_wptr_q] <= dataSave_i[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q    <= 1'b0;
            load_q      <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_cnt_q    <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_cnt_q    <= '0;
            overrun_q   <= 1'b0;
            rx_int_en_q <= 1'b1;
            int_q       <= 1'b0;
        end else begin
            enable_q    <= enable_i;
            if (access) load_q <= rd_value;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_cnt_q    <= tx_cnt_d;
            overrun_q   <= overrun_d;
            rx_int_en_q <= rx_int_en_d;
            int_q       <= (rx_int_en_q & ~rx_empty) | overrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            arm_cnt_q   <= 1'b0;
            txd_start_q <= 1'b0;
            txd_data_q  <= '0;
        end else begin
            txd_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tx_pop) begin
                        txd_data_q  <= tx_mem[tx_rptr_q];
                        txd_start_q <= 1'b1;
                        state_q     <= StLaunch;
                    end
                end
                StLaunch: begin
                    arm_cnt_q <= 1'b0;
                    state_q   <= StArmed;
                end
                StArmed: begin
                    // Give up after two cycles so a dead transmitter cannot stall TX
                    if (txdBusy_i) begin
                        state_q <= StDrain;
                    end else if (arm_cnt_q) begin
                        state_q <= StIdle;
                    end else begin
                        arm_cnt_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (!txdBusy_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign int_o      = int_q;
    assign txdStart_o = txd_start_q;
    assign txdData_o  = txd_data_q;

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Bench for serial_fifo_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference model and a simple transmitter model.
module tb_serial_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0, readEnable_i = 1'b0, mode_i = 1'b0;
    logic [31:0] dataSave_i = '0;
    logic [31:0] dataLoad_o;
    logic        int_o;
    logic        rxdReady_i = 1'b0;
    logic [7:0]  rxdData_i = '0;
    logic        txdBusy_i = 1'b0;
    logic        txdStart_o;
    logic [7:0]  txdData_o;

    always #5 clk = ~clk;

    serial_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .readEnable_i (readEnable_i),
        .mode_i       (mode_i),
        .dataSave_i   (dataSave_i),
        .dataLoad_o   (dataLoad_o),
        .int_o        (int_o),
        .rxdReady_i   (rxdReady_i),
        .rxdData_i    (rxdData_i),
        .txdBusy_i    (txdBusy_i),
        .txdStart_o   (txdStart_o),
        .txdData_o    (txdData_o)
    );

    int unsigned n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    byte unsigned rxq[$], txq[$];
    bit        m_ovr, m_ien, m_int, m_start, m_enq, m_infl, m_seen;
    bit [7:0]  m_txd;
    bit [31:0] m_load;
    int        m_age;
    // Transmitter model
    int  busy_len = 100, busy_wait = 0, busy_cnt = 0;
    bit  rand_busy = 0;
    // Observation log
    int  cyc = 0;
    logic [31:0] last_load;
    byte unsigned start_data[$];
    int  start_time[$];

    task automatic model_reset();
        rxq.delete(); txq.delete();
        m_ovr = 0; m_ien = 1; m_int = 0; m_start = 0; m_enq = 0;
        m_infl = 0; m_seen = 0; m_txd = 0; m_load = 0; m_age = 0;
        busy_wait = 0; busy_cnt = 0; txdBusy_i = 1'b0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[0]    = txq.size() < 16;
        s[1]    = rxq.size() > 0;
        s[2]    = m_ovr;
        s[3]    = (txq.size() == 0) && !m_infl;
        s[4]    = m_ien;
        s[12:8] = 5'(rxq.size());
        return s;
    endfunction

    function automatic logic [31:0] m_read_value();
        if (mode_i) return m_status();
        if (rxq.size() > 0) return {24'b0, rxq[0]};
        return '0;
    endfunction

    function automatic logic [31:0] exp_load();
        if (!enable_i) return '0;
        if (!m_enq) return m_read_value();
        return m_load;
    endfunction

    task automatic model_edge();
        bit acc, launch, next_int, flush_rx, flush_tx;
        logic [31:0] rv;
        acc      = enable_i && !m_enq;
        rv       = m_read_value();
        launch   = !m_infl && (txq.size() > 0) && !txdBusy_i;
        next_int = (m_ien && rxq.size() > 0) || m_ovr;
        flush_rx = 0;
        flush_tx = 0;
        // In-flight byte: one launch cycle, up to two cycles to see busy, then until busy drops
        if (m_infl) begin
            if (m_age >= 1) begin
                if (!m_seen) begin
                    if (txdBusy_i) m_seen = 1;
                    else if (m_age == 2) m_infl = 0;
                end else if (!txdBusy_i) begin
                    m_infl = 0;
                end
            end
            m_age++;
        end
        if (launch) begin
            m_txd = txq.pop_front();
            m_infl = 1; m_age = 0; m_seen = 0;
            busy_wait = 2;
            if (rand_busy) busy_len = $urandom_range(0, 6);
        end
        m_start = launch;
        if (busy_cnt > 0) busy_cnt--;
        if (acc) begin
            if (readEnable_i) begin
                if (!mode_i) begin
                    if (rxq.size() > 0) void'(rxq.pop_front());
                end else begin
                    m_ovr = 0;
                end
            end else if (!mode_i) begin
                if (txq.size() < 16) txq.push_back(dataSave_i[7:0]);
            end else begin
                m_ien = dataSave_i[0];
                flush_rx = dataSave_i[1];
                flush_tx = dataSave_i[2];
            end
            m_load = rv;
        end
        if (rxdReady_i && !flush_rx) begin
            if (rxq.size() < 16) rxq.push_back(rxdData_i);
            else m_ovr = 1;
        end
        if (flush_rx) begin
            rxq.delete();
            m_ovr = 0;
        end
        if (flush_tx) txq.delete();
        m_enq = enable_i;
        m_int = next_int;
    endtask

    // One clock cycle; called at a negedge with inputs already driven
    task automatic tick();
        if (busy_wait > 0) begin
            busy_wait--;
            if (busy_wait == 0) busy_cnt = busy_len;
        end
        txdBusy_i = (busy_cnt > 0);
        #1;
        last_load = dataLoad_o;
        check("dataLoad", dataLoad_o, exp_load());
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("int", int_o, m_int);
        check("txdStart", txdStart_o, m_start);
        check("txdData", txdData_o, m_txd);
        if (txdStart_o === 1'b1) begin
            start_data.push_back(txdData_o);
            start_time.push_back(cyc);
        end
        @(negedge clk);
    endtask

    task automatic rand_rx();
        rxdReady_i = ($urandom_range(0, 2) == 0);
        rxdData_i  = 8'($urandom);
    endtask

    task automatic access(input bit rd, input bit md, input logic [31:0] d, input int len,
                          input bit rnd, output logic [31:0] first);
        enable_i = 1'b1; readEnable_i = rd; mode_i = md; dataSave_i = d;
        first = '0;
        for (int i = 0; i < len; i++) begin
            if (rnd) rand_rx();
            tick();
            if (i == 0) first = last_load;
        end
        enable_i = 1'b0;
        rxdReady_i = 1'b0;
        if (rnd) rand_rx();
        tick();
        rxdReady_i = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rxdReady_i = 1'b1; rxdData_i = b;
        tick();
        rxdReady_i = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        model_reset();
        #1;
        check("rst_int", int_o, 0);
        check("rst_start", txdStart_o, 0);
        check("rst_txd", txdData_o, 0);
        check("rst_load", dataLoad_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access(1, 1, 0, 1, 0, v);
        check("rst_status", v, 32'h0000_0019);

        // Two received bytes, interrupt latency, in-order reads, empty read
        rx_byte(8'h41);
        check("int_lat0", int_o, 0);
        rx_byte(8'h42);
        check("int_lat1", int_o, 1);
        access(1, 1, 0, 1, 0, v);
        check("status_cnt2", v, 32'h0000_021B);
        access(1, 0, 0, 1, 0, v); check("rd_41", v, 32'h41);
        access(1, 0, 0, 1, 0, v); check("rd_42", v, 32'h42);
        access(1, 0, 0, 1, 0, v); check("rd_empty", v, 32'h0);
        check("int_fall", int_o, 0);

        // Overflow by one byte
        for (int i = 0; i <= 16; i++) rx_byte(8'(i));
        check("ovf_int", int_o, 1);
        access(1, 1, 0, 1, 0, v);
        check("ovf_status", v, 32'h0000_101F);
        for (int i = 0; i < 16; i++) begin
            access(1, 0, 0, 1, 0, v);
            check("ovf_rd", v, 32'(i));
        end
        access(1, 1, 0, 1, 0, v);
        check("ovf_clr", v, 32'h0000_0019);

        // Two transmitted bytes against a 100-cycle busy transmitter
        start_data.delete(); start_time.delete();
        busy_len = 100;
        access(0, 0, 32'h55, 1, 0, v);
        access(0, 0, 32'hAA, 1, 0, v);
        for (int i = 0; i < 300; i++) tick();
        check("tx_count", start_data.size(), 2);
        check("tx_d0", (start_data.size() > 0) ? start_data[0] : 8'h00, 32'h55);
        check("tx_d1", (start_data.size() > 1) ? start_data[1] : 8'h00, 32'hAA);
        check("tx_gap", (start_time.size() > 1) && (start_time[1] - start_time[0] > 100), 1);
        access(1, 1, 0, 1, 0, v);
        check("tx_idle", v, 32'h0000_0019);

        // Long enable: one pop, value held
        rx_byte(8'h31);
        rx_byte(8'h32);
        enable_i = 1'b1; readEnable_i = 1'b1; mode_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_val", last_load, 32'h31);
        end
        enable_i = 1'b0;
        tick();
        access(1, 1, 0, 1, 0, v);
        check("hold_cnt1", v, 32'h0000_011B);
        access(1, 0, 0, 1, 0, v);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) rx_byte(8'(8'h60 + i));
        enable_i = 1'b1; readEnable_i = 1'b1; mode_i = 1'b0;
        rxdReady_i = 1'b1; rxdData_i = 8'h77;
        tick();
        check("full_rd", last_load, 32'h60);
        rxdReady_i = 1'b0; enable_i = 1'b0;
        tick();
        access(1, 1, 0, 1, 0, v);
        check("full_status", v, 32'h0000_101B);
        for (int i = 0; i < 16; i++) access(1, 0, 0, 1, 0, v);
        check("full_last", v, 32'h77);

        // Reset in the middle of a drain
        access(0, 0, 32'h99, 1, 0, v);
        for (int i = 0; i < 20; i++) tick();
        check("drain_txd", txdData_o, 32'h99);
        rst_n = 1'b0;
        #1;
        check("arst_txd", txdData_o, 0);
        check("arst_start", txdStart_o, 0);
        check("arst_int", int_o, 0);
        check("arst_load", dataLoad_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 1, 0, 1, 0, v);
        check("arst_status", v, 32'h0000_0019);

        // Random traffic
        rand_busy = 1;
        for (int n = 0; n < 1500; n++) begin
            bit rd, md;
            logic [31:0] d;
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                rand_rx();
                tick();
            end
            rxdReady_i = 1'b0;
            rd = $urandom_range(0, 1);
            md = ($urandom_range(0, 3) == 0);
            d  = $urandom;
            if (md && !rd) begin
                d[0] = ($urandom_range(0, 4) != 0);
                d[1] = ($urandom_range(0, 19) == 0);
                d[2] = ($urandom_range(0, 19) == 0);
            end
            access(rd, md, d, $urandom_range(1, 3), 1, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
